// File: rtl/sha_kt_seq_rom.sv
// sha_kt_seq_rom: one SHA-2 Kt table shared by N_CH round counters, round-robin read, latency 2.
// Build option KT_SHA512_EN compiles in the 80x64 SHA-512 table and makes WORD_W=64 legal.
module sha_kt_seq_rom #(
  parameter  int WORD_W    = 32,
  parameter  int N_CH      = 4,
  parameter  int PRE_ZEROS = 7,
  parameter  int RND_W     = 7,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   start,
  input  logic [N_CH-1:0]   req,
  output logic [N_CH-1:0]   grant,
  output logic [N_CH-1:0]   busy,
  output logic              kt_valid,
  output logic [CH_W-1:0]   kt_ch,
  output logic [RND_W-1:0]  kt_rnd,
  output logic [WORD_W-1:0] kt,
  output logic              kt_last,
  output logic [N_CH-1:0]   done
);

  localparam int N_ROUNDS = (WORD_W == 64) ? 80 : 64;
  localparam int LAST_RND = PRE_ZEROS + N_ROUNDS - 1;
  localparam int DEPTH    = 1 << RND_W;
  localparam int CW1      = CH_W + 1;
  localparam logic [RND_W-1:0] LAST_IDX = RND_W'(LAST_RND);

`ifdef KT_SHA512_EN
  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
    $error("sha_kt_seq_rom: WORD_W must be 32 or 64");
  end
`else
  if (WORD_W != 32) begin : g_bad_word_w
    $error("sha_kt_seq_rom: WORD_W must be 32 unless KT_SHA512_EN is defined");
  end
`endif
  if (N_CH < 1 || N_CH > 8) begin : g_bad_n_ch
    $error("sha_kt_seq_rom: N_CH must be 1..8");
  end
  if (LAST_RND >= DEPTH) begin : g_bad_rnd_w
    $error("sha_kt_seq_rom: RND_W too small for PRE_ZEROS+N_ROUNDS-1");
  end

  localparam logic [64*32-1:0] K256 = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

`ifdef KT_SHA512_EN
  localparam logic [80*64-1:0] K512 = {
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };
`endif

  // Table image: PRE_ZEROS fill slots, then K[0..N_ROUNDS-1], zero beyond.
  function automatic logic [WORD_W-1:0] kt_rom(input logic [RND_W-1:0] idx);
    int k;
    k      = int'(idx) - PRE_ZEROS;
    kt_rom = '0;
    if (k >= 0 && k < N_ROUNDS) begin
`ifdef KT_SHA512_EN
      if (WORD_W == 64) kt_rom = WORD_W'(K512[(79-k)*64 +: 64]);
      else              kt_rom = WORD_W'(K256[(63-k)*32 +: 32]);
`else
      kt_rom = WORD_W'(K256[(63-k)*32 +: 32]);
`endif
    end
  endfunction

  typedef enum logic {CH_IDLE, CH_RUN} ch_state_t;

  ch_state_t          st_q  [N_CH];
  ch_state_t          st_d  [N_CH];
  logic [RND_W-1:0]   rnd_q [N_CH];
  logic [RND_W-1:0]   rnd_d [N_CH];
  logic [CH_W-1:0]    ptr_q, ptr_d;
  logic [N_CH-1:0]    eligible;
  logic               gnt_any;
  logic [CH_W-1:0]    gnt_idx;
  logic [CW1-1:0]     cand;
  logic [RND_W-1:0]   rd_addr;

  logic               vld_p1_q, vld_p1_d;
  logic [CH_W-1:0]    ch_p1_q, ch_p1_d;
  logic [RND_W-1:0]   rnd_p1_q, rnd_p1_d;
  logic               last_p1_q, last_p1_d;
  logic [WORD_W-1:0]  rd_p1_q, rd_p1_d;

  logic               kt_valid_q, kt_valid_d;
  logic [CH_W-1:0]    kt_ch_q, kt_ch_d;
  logic [RND_W-1:0]   kt_rnd_q, kt_rnd_d;
  logic [WORD_W-1:0]  kt_q, kt_d;
  logic               kt_last_q, kt_last_d;
  logic [N_CH-1:0]    done_q, done_d;

  // Second BRAM port: tied-off write port so the table maps onto a true dual-port block.
  logic               pb_we;
  logic [RND_W-1:0]   pb_addr;
  logic [WORD_W-1:0]  pb_wdata;
  (* keep = "true" *) logic [WORD_W-1:0] pb_mem_unused [DEPTH];

  assign pb_we    = 1'b0;
  assign pb_addr  = '0;
  assign pb_wdata = '0;

  always_ff @(posedge CLK) begin
    if (pb_we) pb_mem_unused[pb_addr] <= pb_wdata;
  end

  // Stage 0: round-robin arbitration, counter update, table address
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_CH; i++) begin
      eligible[i] = req[i] && (st_q[i] == CH_RUN) && !start[i];
      busy[i]     = (st_q[i] == CH_RUN);
    end
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = {1'b0, ptr_q} + CW1'(k);
      if (cand >= CW1'(N_CH)) cand = cand - CW1'(N_CH);
      if (!gnt_any && eligible[cand[CH_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[CH_W-1:0];
      end
    end
    grant = '0;
    if (gnt_any) grant[gnt_idx] = 1'b1;

    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);

    for (int i = 0; i < N_CH; i++) begin
      st_d[i]  = st_q[i];
      rnd_d[i] = rnd_q[i];
      if (start[i]) begin
        st_d[i]  = CH_RUN;
        rnd_d[i] = '0;
      end else if (grant[i]) begin
        if (rnd_q[i] == LAST_IDX) begin
          st_d[i]  = CH_IDLE;
          rnd_d[i] = '0;
        end else begin
          rnd_d[i] = rnd_q[i] + RND_W'(1);
        end
      end
    end

    rd_addr   = rnd_q[gnt_idx];
    vld_p1_d  = gnt_any;
    ch_p1_d   = gnt_idx;
    rnd_p1_d  = rd_addr;
    last_p1_d = (rd_addr == LAST_IDX);
    rd_p1_d   = kt_rom(rd_addr);
  end

  // Stage 1 -> 2: output register, everything zeroed when not valid
  always_comb begin
    kt_valid_d = vld_p1_q;
    kt_ch_d    = vld_p1_q ? ch_p1_q  : '0;
    kt_rnd_d   = vld_p1_q ? rnd_p1_q : '0;
    kt_d       = vld_p1_q ? rd_p1_q  : '0;
    kt_last_d  = vld_p1_q && last_p1_q;
    done_d     = '0;
    if (vld_p1_q && last_p1_q) done_d[ch_p1_q] = 1'b1;
  end

  // Stage 1: table read register (BRAM data, no reset)
  always_ff @(posedge CLK) begin
    rd_p1_q <= rd_p1_d;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]  <= CH_IDLE;
        rnd_q[i] <= '0;
      end
      ptr_q      <= '0;
      vld_p1_q   <= 1'b0;
      ch_p1_q    <= '0;
      rnd_p1_q   <= '0;
      last_p1_q  <= 1'b0;
      kt_valid_q <= 1'b0;
      kt_ch_q    <= '0;
      kt_rnd_q   <= '0;
      kt_q       <= '0;
      kt_last_q  <= 1'b0;
      done_q     <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]  <= st_d[i];
        rnd_q[i] <= rnd_d[i];
      end
      ptr_q      <= ptr_d;
      vld_p1_q   <= vld_p1_d;
      ch_p1_q    <= ch_p1_d;
      rnd_p1_q   <= rnd_p1_d;
      last_p1_q  <= last_p1_d;
      kt_valid_q <= kt_valid_d;
      kt_ch_q    <= kt_ch_d;
      kt_rnd_q   <= kt_rnd_d;
      kt_q       <= kt_d;
      kt_last_q  <= kt_last_d;
      done_q     <= done_d;
    end
  end

  assign kt_valid = kt_valid_q;
  assign kt_ch    = kt_ch_q;
  assign kt_rnd   = kt_rnd_q;
  assign kt       = kt_q;
  assign kt_last  = kt_last_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sha_kt_seq_rom.sv
// Bench for sha_kt_seq_rom (4 channels, SHA-256): Kt reference derived from cube roots of primes,
// channel/arbiter behaviour modelled with per-channel round counters and a rotating pointer.
module tb_sha_kt_seq_rom;

  localparam int WORD_W    = 32;
  localparam int N_CH      = 4;
  localparam int PRE_ZEROS = 7;
  localparam int RND_W     = 7;
  localparam int CH_W      = 2;
  localparam int LAST      = PRE_ZEROS + 64 - 1;

  logic              CLK = 1'b0;
  logic              rst_n;
  logic [N_CH-1:0]   start, req, grant, busy, done;
  logic              kt_valid, kt_last;
  logic [CH_W-1:0]   kt_ch;
  logic [RND_W-1:0]  kt_rnd;
  logic [WORD_W-1:0] kt;

  always #5 CLK = ~CLK;

  sha_kt_seq_rom #(.WORD_W(WORD_W), .N_CH(N_CH), .PRE_ZEROS(PRE_ZEROS), .RND_W(RND_W)) dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .req(req), .grant(grant), .busy(busy),
    .kt_valid(kt_valid), .kt_ch(kt_ch), .kt_rnd(kt_rnd), .kt(kt), .kt_last(kt_last), .done(done)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] kref [64];
  bit          armed [N_CH];
  int          nxt   [N_CH];
  int          ptr;
  bit          pv;
  int          pch, prnd;
  int          phase, cyc, start_cyc, first_cyc, n_valid;
  int          done_seq[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_kt(input int r);
    if (r < PRE_ZEROS || r - PRE_ZEROS >= 64) return 32'h0;
    return kref[r - PRE_ZEROS];
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) begin
      armed[c] = 1'b0;
      nxt[c]   = 0;
    end
    ptr = 0;
    pv  = 1'b0;
    pch = 0;
    prnd = 0;
  endfunction

  // One clock: drive inputs, check the combinational grant, then check the registered outputs.
  task automatic step(input logic [N_CH-1:0] st, input logic [N_CH-1:0] rq);
    int              g, r, c;
    logic [N_CH-1:0] eg, eb;
    logic            lst;
    start = st;
    req   = rq;
    #1;
    g  = -1;
    eg = '0;
    eb = '0;
    for (int k = 0; k < N_CH; k++) begin
      c = (ptr + k) % N_CH;
      if (g < 0 && rq[c] && armed[c] && !st[c]) g = c;
      eb[k] = armed[k];
    end
    if (g >= 0) eg[g] = 1'b1;
    chk("grant", grant, eg);
    chk("busy", busy, eb);
    for (int k = 0; k < N_CH; k++) begin
      if (st[k] && rq[k]) chk("start_wins", grant[k], 0);
      if (rq[k] && !armed[k]) chk("idle_nogrant", grant[k], 0);
    end

    @(posedge CLK);
    #1;
    cyc++;
    lst = pv && (prnd == LAST);
    chk("kt_valid", kt_valid, pv);
    chk("kt_ch", kt_ch, pv ? 64'(pch) : 64'd0);
    chk("kt_rnd", kt_rnd, pv ? 64'(prnd) : 64'd0);
    chk("kt", kt, pv ? 64'(ref_kt(prnd)) : 64'd0);
    chk("kt_last", kt_last, lst);
    chk("done", done, lst ? 64'(1 << pch) : 64'd0);
    if (kt_valid) begin
      if (phase == 2) begin
        n_valid++;
        if (first_cyc < 0) first_cyc = cyc;
        if (kt_rnd == 7) chk("k0_lit", kt, 32'h428a2f98);
        if (kt_rnd == 70) begin
          chk("k63_lit", kt, 32'hc67178f2);
          chk("last70", kt_last, 1);
          chk("done70", done, 4'b0001);
        end
      end
      if (phase == 3 && done != 0) done_seq.push_back(int'(kt_ch));
    end

    r = (g >= 0) ? nxt[g] : 0;
    for (int k = 0; k < N_CH; k++) begin
      if (st[k]) begin
        armed[k] = 1'b1;
        nxt[k]   = 0;
      end
    end
    if (g >= 0) begin
      nxt[g]++;
      if (r == LAST) armed[g] = 1'b0;
      ptr = (g + 1) % N_CH;
    end
    pv   = (g >= 0);
    pch  = (g >= 0) ? g : 0;
    prnd = r;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = '0;
    req   = '0;
    #1;
    chk("rst_valid", kt_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_kt", kt, 0);
    chk("rst_done", done, 0);
    @(posedge CLK);
    #1;
    rst_n = 1'b1;
    cyc++;
    model_reset();
  endtask

  initial begin
    int  p, n, rst_at;
    bit  pr;
    real x, fr;
    logic [N_CH-1:0] st;

    rst_n = 1'b0;
    start = '0;
    req   = '0;
    phase = 0;
    cyc   = 0;
    model_reset();

    p = 2;
    n = 0;
    while (n < 64) begin
      pr = 1'b1;
      for (int d = 2; d * d <= p; d++) if (p % d == 0) pr = 1'b0;
      if (pr) begin
        x  = $pow(real'(p), 1.0 / 3.0);
        x  = x - (x * x * x - real'(p)) / (3.0 * x * x);
        fr = x - $floor(x);
        kref[n] = 32'(longint'($floor(fr * 4294967296.0)));
        n++;
      end
      p++;
    end

    repeat (2) @(posedge CLK);
    #1;
    chk("init_valid", kt_valid, 0);
    chk("init_busy", busy, 0);
    chk("init_kt", kt, 0);
    chk("init_grant", grant, 0);
    rst_n = 1'b1;

    // Single channel, request held through and past the last round
    phase     = 2;
    n_valid   = 0;
    first_cyc = -1;
    start_cyc = cyc;
    step(4'b0001, 4'b0001);
    repeat (80) step(4'b0000, 4'b0001);
    chk("valid_cnt", n_valid, 71);
    chk("first_lat", first_cyc - start_cyc, 3);
    phase = 0;

    // All channels started together and requesting every cycle
    do_reset();
    phase = 3;
    step(4'b1111, 4'b1111);
    repeat (300) step(4'b0000, 4'b1111);
    phase = 0;
    chk("done_cnt", done_seq.size(), 4);
    for (int i = 0; i < done_seq.size() && i < 4; i++) chk("done_order", done_seq[i], i);

    // ch2 restarted mid-message while ch0 runs; ch1 idle but requesting
    step(4'b0101, 4'b0111);
    for (int i = 0; i < 200 && nxt[2] != 30; i++) step(4'b0000, 4'b0111);
    chk("restart_rnd", nxt[2], 30);
    step(4'b0100, 4'b0111);
    repeat (250) step(4'b0000, 4'b0111);

    // Random requests with gaps, occasional (re)starts and one reset mid-stream
    rst_at = $urandom_range(300, 1500);
    for (int i = 0; i < 2500; i++) begin
      st = '0;
      for (int c = 0; c < N_CH; c++) if ($urandom_range(0, 59) == 0) st[c] = 1'b1;
      if (i == rst_at) do_reset();
      else step(st, 4'($urandom));
    end
    repeat (4) step(4'b0000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
